// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types plus the aligned link-address compare helper.
package cpu_types_pkg;
  typedef enum logic {IDLE, DONE} dmem_state_t;
  function automatic logic line_match(input logic [63:0] a, input logic [63:0] b,
                                      input int unsigned lsb);
    return ((a ^ b) >> lsb) == 64'd0;
  endfunction
endpackage

// File: rtl/dmem_link_reg.sv
// dmem_link_reg: LL/SC link register with set/clear logic and sc_ok; remote snoop clearing when DMEM_LINK_SNOOP_EN is defined.
module dmem_link_reg import cpu_types_pkg::*; #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ALIGN_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef DMEM_LINK_SNOOP_EN
  input  logic              snoop_inv_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
`endif
  input  logic              ll_done_i,
  input  logic              sc_done_i,
  input  logic              st_done_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              sc_ok_o
);
  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              link_hit, snoop_link, snoop_req;
  assign link_hit = line_match(64'(link_addr_q), 64'(req_addr_i), ALIGN_LSB);
`ifdef DMEM_LINK_SNOOP_EN
  assign snoop_link = snoop_inv_i & line_match(64'(snoop_addr_i), 64'(link_addr_q), ALIGN_LSB);
  assign snoop_req  = snoop_inv_i & line_match(64'(snoop_addr_i), 64'(req_addr_i), ALIGN_LSB);
`else
  assign snoop_link = 1'b0;
  assign snoop_req  = 1'b0;
`endif
  // a snoop to the line being linked this very cycle beats the LL
  always_comb begin
    link_addr_d  = ll_done_i ? req_addr_i : link_addr_q;
    link_valid_d = ll_done_i ? ~snoop_req
                             : link_valid_q & ~snoop_link & ~sc_done_i & ~(st_done_i & link_hit);
  end
  assign sc_ok_o = link_valid_q & link_hit & ~snoop_req;
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one dcache request per memory instruction, stall until dhit, load capture and LL/SC.
// Optional remote link invalidation is enabled with DMEM_LINK_SNOOP_EN.
module dmem_access_ctrl import cpu_types_pkg::*; #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ALIGN_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef DMEM_LINK_SNOOP_EN
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
`endif
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic              req_atomic,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              halt_in,
  input  logic              pipe_adv,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              datomic,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              sc_result
);
  dmem_state_t       state_q, state_d;
  logic              pend_q, pend_d, sc_res_q, sc_res_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              mem_req, is_sc, req_act, sc_ok, sc_fail, issue, done;
  assign mem_req = (req_ren | req_wen) & ~halt_in;
  assign is_sc   = req_wen & req_atomic;
  // pend_q keeps an already-issued access alive if halt_in rises before dhit
  assign req_act = (state_q == IDLE) & (mem_req | pend_q);
  assign sc_fail = req_act & ~pend_q & is_sc & ~sc_ok;
  assign issue   = req_act & ~sc_fail;
  assign done    = issue & dhit;
  dmem_link_reg #(.ADDR_W(ADDR_W), .ALIGN_LSB(ALIGN_LSB)) u_link (
    .CLK        (CLK),
    .RST        (RST),
`ifdef DMEM_LINK_SNOOP_EN
    .snoop_inv_i (snoop_inv),
    .snoop_addr_i(snoop_addr),
`endif
    .ll_done_i  (done & req_ren & req_atomic),
    .sc_done_i  ((done & is_sc) | sc_fail),
    .st_done_i  (done & req_wen & ~req_atomic),
    .req_addr_i (req_addr),
    .sc_ok_o    (sc_ok)
  );
  always_comb begin
    state_d     = (state_q == IDLE) ? (((done | sc_fail) & ~pipe_adv) ? DONE : IDLE)
                                    : (pipe_adv ? IDLE : DONE);
    pend_d      = issue & ~dhit;
    load_data_d = (done & req_ren) ? dmemload : load_data_q;
    sc_res_d    = (pipe_adv | sc_fail) ? 1'b0 : (done & is_sc) ? 1'b1 : sc_res_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      load_data_q <= '0;
      sc_res_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      load_data_q <= load_data_d;
      sc_res_q    <= sc_res_d;
    end
  end
  assign dmemREN   = issue & req_ren;
  assign dmemWEN   = issue & req_wen;
  assign datomic   = issue & is_sc;
  assign dmemaddr  = req_addr;
  assign dmemstore = req_wdata;
  assign stall     = req_act & ~dhit & ~sc_fail;
  assign load_data = load_data_q;
  assign sc_result = sc_res_q | (done & is_sc);
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table, directed LL/SC/reset/halt sequences and a randomized instruction-level model.
module tb_dmem_access_ctrl;
  logic        CLK = 1'b0, RST;
  logic        req_ren, req_wen, req_atomic, halt_in, pipe_adv, dhit;
  logic [31:0] req_addr, req_wdata, dmemload;
  logic        dmemREN, dmemWEN, datomic, stall, sc_result;
  logic [31:0] dmemaddr, dmemstore, load_data;
`ifdef DMEM_LINK_SNOOP_EN
  logic        snoop_inv;
  logic [31:0] snoop_addr;
`endif
  int passed = 0, total = 0;

  always #5 CLK = ~CLK;

  dmem_access_ctrl dut (
    .CLK(CLK), .RST(RST),
`ifdef DMEM_LINK_SNOOP_EN
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
`endif
    .req_ren(req_ren), .req_wen(req_wen), .req_atomic(req_atomic), .req_addr(req_addr),
    .req_wdata(req_wdata), .halt_in(halt_in), .pipe_adv(pipe_adv), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall(stall), .load_data(load_data),
    .sc_result(sc_result)
  );

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [3:0]  exp;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic chk_o(input string n, input logic [3:0] e);
    chk(n, 32'({dmemREN, dmemWEN, datomic, stall}), 32'(e));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // ctl = {ren, wen, atomic, halt, pipe_adv, dhit}
  task automatic drive(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ld);
    {req_ren, req_wen, req_atomic, halt_in, pipe_adv, dhit} = ctl;
    req_addr  = a;
    req_wdata = wd;
    dmemload  = ld;
    #1;
  endtask

  task automatic do_reset;
    drive(6'b000000, 0, 0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // one-cycle LL/load/store with immediate hit and pipe advance
  task automatic quick(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] ld);
    drive(ctl, a, 32'h0, ld);
    tick();
  endtask

  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  vec_t vt[8];
  logic [31:0] pool[5];

  initial begin
    int count;
`ifdef DMEM_LINK_SNOOP_EN
    snoop_inv  = 1'b0;
    snoop_addr = '0;
`endif
    vt[0] = '{6'b100010, 32'h40,  4'b1001};
    vt[1] = '{6'b100011, 32'h44,  4'b1000};
    vt[2] = '{6'b010010, 32'h48,  4'b0101};
    vt[3] = '{6'b100110, 32'h4C,  4'b0000};
    vt[4] = '{6'b011010, 32'h80,  4'b0000};
    vt[5] = '{6'b101010, 32'h80,  4'b1001};
    vt[6] = '{6'b000010, 32'h90,  4'b0000};
    vt[7] = '{6'b010011, 32'h94,  4'b0100};
    pool  = '{32'h80, 32'h82, 32'h84, 32'h40, 32'h100};

    do_reset();
    chk_o("reset_strobes", 4'b0000);
    chk("reset_load_data", load_data, 0);
    chk("reset_sc_result", 32'(sc_result), 0);

    foreach (vt[i]) begin
      do_reset();
      drive(vt[i].ctl, vt[i].addr, 32'hA5A5_0000 + i, 0);
      chk_o($sformatf("vec%0d", i), vt[i].exp);
      if (vt[i].exp[3:2] != 0) chk($sformatf("vec%0d_addr", i), dmemaddr, vt[i].addr);
    end

    // load with dhit after 3 cycles, then hold in DONE
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(6'b100000, 32'h40, 0, 0);
      chk_o("ld_wait", 4'b1001);
      tick();
    end
    drive(6'b100001, 32'h40, 0, 32'hDEADBEEF);
    chk_o("ld_hit", 4'b1000);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(6'b100000, 32'h40, 0, 0);
      chk_o("ld_hold", 4'b0000);
      chk("ld_data", load_data, 32'hDEADBEEF);
      tick();
    end
    drive(6'b100010, 32'h40, 0, 0);
    chk_o("ld_adv", 4'b0000);
    tick();
    count = 0;
    for (int k = 1; k <= 2; k++) begin
      drive(6'b100011, 32'h40, 0, 32'h1111 * k);
      if (dmemREN) count++;
      tick();
    end
    chk("b2b_count", count, 2);
    chk("b2b_data", load_data, 32'h2222);

    // LL then SC success, then a second SC fails
    do_reset();
    quick(6'b101011, 32'h80, 32'h5);
    drive(6'b011000, 32'h80, 32'h1, 0);
    chk_o("sc_issue", 4'b0111);
    chk("sc_wdata", dmemstore, 32'h1);
    tick();
    drive(6'b011001, 32'h80, 32'h1, 0);
    chk("sc_res_hit", 32'(sc_result), 1);
    tick();
    drive(6'b011000, 32'h80, 32'h1, 0);
    chk("sc_res_hold", 32'(sc_result), 1);
    chk_o("sc_done", 4'b0000);
    tick();
    quick(6'b000010, 0, 0);
    chk("sc_res_clr", 32'(sc_result), 0);
    drive(6'b011000, 32'h80, 32'h1, 0);
    chk_o("sc2_fail", 4'b0000);
    chk("sc2_res", 32'(sc_result), 0);
    tick();
    quick(6'b000010, 0, 0);

    // aligned store clears the link, unrelated store does not
    quick(6'b101011, 32'h80, 0);
    quick(6'b010011, 32'h82, 0);
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("sc_after_st", 4'b0000);
    tick();
    quick(6'b000010, 0, 0);
    quick(6'b101011, 32'h80, 0);
    quick(6'b010011, 32'h40, 0);
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("sc_other_st", 4'b0111);
    drive(6'b011011, 32'h80, 0, 0);
    tick();

`ifdef DMEM_LINK_SNOOP_EN
    quick(6'b101011, 32'h80, 0);
    snoop_inv = 1'b1; snoop_addr = 32'h80;
    quick(6'b000000, 0, 0);
    snoop_inv = 1'b0;
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("snoop_hit_sc", 4'b0000);
    tick();
    quick(6'b000010, 0, 0);
    quick(6'b101011, 32'h80, 0);
    snoop_inv = 1'b1; snoop_addr = 32'h84;
    quick(6'b000000, 0, 0);
    snoop_inv = 1'b0;
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("snoop_miss_sc", 4'b0111);
    drive(6'b011011, 32'h80, 0, 0);
    tick();
    snoop_inv = 1'b1; snoop_addr = 32'h80;
    quick(6'b101011, 32'h80, 0);
    snoop_inv = 1'b0;
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("snoop_ll_race", 4'b0000);
    tick();
    quick(6'b000010, 0, 0);
`endif

    // reset while a load waits for dhit
    do_reset();
    quick(6'b101011, 32'h80, 0);
    quick(6'b100011, 32'h40, 32'h1234);
    drive(6'b100000, 32'h40, 0, 0);
    chk_o("rst_pre", 4'b1001);
    chk("rst_pre_data", load_data, 32'h1234);
    drive(6'b000000, 0, 0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_o("rst_strobes", 4'b0000);
    chk("rst_load_data", load_data, 0);
    drive(6'b011000, 32'h80, 0, 0);
    chk_o("rst_link", 4'b0000);
    tick();
    quick(6'b000010, 0, 0);

    // halt blocks a new store but not one already issued
    drive(6'b010100, 32'h40, 0, 0);
    chk_o("halt_new", 4'b0000);
    tick();
    drive(6'b010000, 32'h40, 0, 0);
    tick();
    drive(6'b010100, 32'h40, 0, 0);
    chk_o("halt_pend", 4'b0101);
    drive(6'b010101, 32'h40, 0, 0);
    chk_o("halt_pend_hit", 4'b0100);
    tick();
    drive(6'b010100, 32'h40, 0, 0);
    chk_o("halt_done", 4'b0000);
    quick(6'b000010, 0, 0);

    // randomized instruction stream against a link/data model
    begin
      logic        mv, ren, wen, at, sc;
      logic [31:0] ma, mld, a, wd, ld;
      int          kind, lat;
      do_reset();
      mv = 1'b0; ma = '0; mld = '0;
      for (int n = 0; n < 150; n++) begin
        kind = $urandom_range(0, 3);
        a    = pool[$urandom_range(0, 4)];
        lat  = $urandom_range(0, 2);
        wd   = $urandom;
        ld   = $urandom;
        ren  = (kind == 0) || (kind == 2);
        wen  = !ren;
        at   = kind >= 2;
        sc   = kind == 3;
        if ($urandom_range(0, 7) == 0) begin
          drive({ren, wen, at, 3'b110}, a, wd, ld);
          chk_o("rnd_halt", 4'b0000);
          tick();
        end else if (sc && !(mv && same_line(ma, a))) begin
          drive({ren, wen, at, 3'b000}, a, wd, ld);
          chk_o("rnd_scfail", 4'b0000);
          chk("rnd_scfail_res", 32'(sc_result), 0);
          tick();
          mv = 1'b0;
          drive({ren, wen, at, 3'b010}, a, wd, ld);
          chk_o("rnd_scfail_done", 4'b0000);
          tick();
        end else begin
          for (int c = 0; c < lat; c++) begin
            drive({ren, wen, at, 3'b000}, a, wd, ld);
            chk_o("rnd_wait", {ren, wen, sc, 1'b1});
            chk("rnd_addr", dmemaddr, a);
            tick();
          end
          drive({ren, wen, at, 3'b001}, a, wd, ld);
          chk_o("rnd_hit", {ren, wen, sc, 1'b0});
          tick();
          if (ren) mld = ld;
          if (kind == 2) begin mv = 1'b1; ma = a; end
          if (sc || (kind == 1 && same_line(ma, a))) mv = 1'b0;
          for (int c = $urandom_range(0, 2); c > 0; c--) begin
            drive({ren, wen, at, 3'b000}, a, wd, ld);
            chk_o("rnd_done", 4'b0000);
            chk("rnd_data", load_data, mld);
            chk("rnd_sc_res", 32'(sc_result), 32'(sc));
            tick();
          end
          drive({ren, wen, at, 3'b010}, a, wd, ld);
          chk_o("rnd_adv", 4'b0000);
          tick();
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
